// File: rtl/ps2_key_tracker.sv
// Tracks the held/released state of the Bomberman keys from a PS/2 set-2 byte
// stream. Resolves E0/F0/E1 prefixes and emits one-cycle press/release events.
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | waiting for a make code or a prefix
// EXT     | E0 seen, next code is extended make
// BRK     | F0 seen, next code is a break
// EXT_BRK | E0 and F0 seen (either order), extended break
// SKIP    | inside the 8-byte E1 pause sequence
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scan_byte,
    input  logic        scan_valid,
    output logic [10:0] key_state,
    output logic        key_event,
    output logic [3:0]  key_index,
    output logic        key_make,
    output logic        seq_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } state_t;

    state_t          state, next_state;
    logic [2:0]      skip_cnt, next_skip;
    logic [CW-1:0]   to_cnt;
    logic            timeout_hit;

    logic            res_go;
    logic            res_ext;
    logic            res_brk;
    logic            map_valid;
    logic [3:0]      map_idx;
    logic            key_held;
    logic            do_event;
    logic [10:0]     toggle_mask;

    // Returns {valid, index} for a final code byte.
    function automatic logic [4:0] map_code(input logic ext, input logic [7:0] code);
        logic [4:0] r;
        r = 5'd0;
        if (ext) begin
            case (code)
                8'h75:   r = {1'b1, 4'd5};
                8'h6B:   r = {1'b1, 4'd6};
                8'h72:   r = {1'b1, 4'd7};
                8'h74:   r = {1'b1, 4'd8};
                default: r = 5'd0;
            endcase
        end else begin
            case (code)
                8'h1D:   r = {1'b1, 4'd0};
                8'h1C:   r = {1'b1, 4'd1};
                8'h1B:   r = {1'b1, 4'd2};
                8'h23:   r = {1'b1, 4'd3};
                8'h29:   r = {1'b1, 4'd4};
                8'h5A:   r = {1'b1, 4'd9};
                8'h76:   r = {1'b1, 4'd10};
                default: r = 5'd0;
            endcase
        end
        return r;
    endfunction

    // A byte arriving in the same cycle as the timeout takes priority.
    assign timeout_hit = (state != IDLE) && !scan_valid && (to_cnt == TO_LAST);

    always_comb begin
        next_state = state;
        next_skip  = skip_cnt;
        res_go     = 1'b0;
        res_ext    = 1'b0;
        res_brk    = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    case (scan_byte)
                        8'hE0: next_state = EXT;
                        8'hF0: next_state = BRK;
                        8'hE1: begin
                            next_state = SKIP;
                            next_skip  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: next_state = IDLE;
                        default: res_go = 1'b1;
                    endcase
                end
                EXT: begin
                    case (scan_byte)
                        8'hF0: next_state = EXT_BRK;
                        8'hE0: next_state = EXT;
                        default: begin
                            res_go     = 1'b1;
                            res_ext    = 1'b1;
                            next_state = IDLE;
                        end
                    endcase
                end
                BRK: begin
                    case (scan_byte)
                        8'hF0: next_state = BRK;
                        8'hE0: next_state = EXT_BRK;
                        default: begin
                            res_go     = 1'b1;
                            res_brk    = 1'b1;
                            next_state = IDLE;
                        end
                    endcase
                end
                EXT_BRK: begin
                    case (scan_byte)
                        8'hE0, 8'hF0: next_state = EXT_BRK;
                        default: begin
                            res_go     = 1'b1;
                            res_ext    = 1'b1;
                            res_brk    = 1'b1;
                            next_state = IDLE;
                        end
                    endcase
                end
                SKIP: begin
                    next_skip = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        next_skip  = 3'd0;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end else if (timeout_hit) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        {map_valid, map_idx} = map_code(res_ext, scan_byte);
        key_held    = key_state[map_idx];
        // Typematic makes and breaks of idle keys are not state changes.
        do_event    = res_go && map_valid && (res_brk ? key_held : !key_held);
        toggle_mask = do_event ? (11'd1 << map_idx) : 11'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= next_state;
            skip_cnt <= next_skip;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || scan_valid || state == IDLE || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_state   <= 11'd0;
            key_event   <= 1'b0;
            key_index   <= 4'd0;
            key_make    <= 1'b0;
            seq_timeout <= 1'b0;
        end else begin
            key_state   <= key_state ^ toggle_mask;
            key_event   <= do_event;
            seq_timeout <= timeout_hit;
            if (do_event) begin
                key_index <= map_idx;
                key_make  <= !res_brk;
            end
        end
    end

endmodule
